// File: rtl/button_stepper_pkg.sv
// Shared types and constants for the button stepper.
// State encoding, default timing and counter widths.
package button_stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_REPEAT
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  localparam int TIMER_W = 32;
  localparam int DEB_W   = 16;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a debounce counter.
// The stable level flips only after a sustained difference.
module button_debounce
  import button_stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [DEB_W-1:0] LAST =
    DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic [DEB_W-1:0] count;

  assign sync = sync_q[1];

  // bring the asynchronous pin into the clock domain
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw};
  end

  // any glitch back to the stable level restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      count  <= '0;
    end else if (sync == stable) begin
      count <= '0;
    end else if (count == LAST) begin
      stable <= sync;
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_stepper.sv
// Turns up/down push-buttons into single-cycle step strobes
// with press-and-hold auto-repeat for a step counter.
module button_stepper
  import button_stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic en,
  output logic upnotdown,
  output logic busy
);

  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  localparam logic [TIMER_W-1:0] DELAY_LAST =
    TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST =
    TIMER_W'(REPEAT_PERIOD - 1);

  logic stable_up;
  logic stable_down;
  logic press_up;
  logic press_down;

  state_t             state;
  state_t             state_n;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_n;
  logic               active_dir;
  logic               active_dir_n;
  logic               en_n;
  logic               dir_n;
  logic               held;
  logic               other;
  logic               leave;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up),
    .stable(stable_up)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down),
    .stable(stable_down)
  );

  // register debounced levels at the FSM boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      press_up   <= 1'b0;
      press_down <= 1'b0;
    end else begin
      press_up   <= stable_up;
      press_down <= stable_down;
    end
  end

  assign held  = active_dir ? press_up : press_down;
  assign other = active_dir ? press_down : press_up;
  assign leave = !held || other;

  // next state, timer and step strobe
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    active_dir_n = active_dir;
    en_n         = 1'b0;
    dir_n        = upnotdown;
    unique case (state)
      IDLE: begin
        if (press_up ^ press_down) begin
          en_n         = 1'b1;
          dir_n        = press_up;
          active_dir_n = press_up;
          timer_n      = '0;
          state_n      = HOLD_DELAY;
        end
      end
      HOLD_DELAY: begin
        if (leave) begin
          state_n = IDLE;
        end else if (REPEAT_EN && timer == DELAY_LAST) begin
          en_n    = 1'b1;
          timer_n = '0;
          state_n = HOLD_REPEAT;
        end else if (REPEAT_EN) begin
          timer_n = timer + 1'b1;
        end
      end
      HOLD_REPEAT: begin
        if (leave) begin
          state_n = IDLE;
        end else if (timer == PERIOD_LAST) begin
          en_n    = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state, timer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      active_dir <= 1'b1;
      en         <= 1'b0;
      upnotdown  <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      active_dir <= active_dir_n;
      en         <= en_n;
      upnotdown  <= dir_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
